// File: rtl/memaccess_ctrl_if.sv
// Command, memory-port and status signals of the LC3 memory-access stage.
// slave is the controller's view; master is the view of whatever drives it.
interface memaccess_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [1:0]    mem_state;
  logic          M_control;
  logic [AW-1:0] M_addr;
  logic [DW-1:0] M_Data;
  logic [DW-1:0] DMem_dout;
  logic          DMem_rdy;
  logic [AW-1:0] DMem_addr;
  logic [DW-1:0] DMem_din;
  logic          DMem_rd;
  logic          DMem_en;
  logic [DW-1:0] memout;
  logic          busy;
  logic          done;
  logic          err;

  // Memory handshake: a phase is offered while DMem_en=1 and completes on the
  // cycle DMem_rdy=1; DMem_addr/DMem_rd/DMem_din stay stable until then.
  modport slave (
    input  mem_state, M_control, M_addr, M_Data, DMem_dout, DMem_rdy,
    output DMem_addr, DMem_din, DMem_rd, DMem_en, memout, busy, done, err
  );

  modport master (
    output mem_state, M_control, M_addr, M_Data, DMem_dout, DMem_rdy,
    input  DMem_addr, DMem_din, DMem_rd, DMem_en, memout, busy, done, err
  );
endinterface

// File: rtl/memaccess_ctrl.sv
// Memory-access stage controller: sequences direct/indirect reads and writes
// over a variable-latency memory port, with an optional per-phase timeout.
module memaccess_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 0,
  parameter int TW      = 8
) (
  input  logic            clock,
  input  logic            reset,
  memaccess_ctrl_if.slave bus,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    ACC  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [1:0] OP_IND = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [1:0]    op_q;
  logic [DW-1:0] memout_q;
  logic [TW-1:0] cnt_q;
  logic          in_phase;
  logic          is_write;
  logic          abort;
  logic          en;

  always_comb begin
    in_phase = (state_q == PTR) || (state_q == ACC);
    is_write = (state_q == ACC) && (op_q == OP_WR);
    abort    = (TIMEOUT != 0) && in_phase && !bus.DMem_rdy && (cnt_q == TW'(TIMEOUT));
    state_d  = state_q;
    case (state_q)
      IDLE: if (bus.mem_state != OP_NOP)
              state_d = (bus.M_control || bus.mem_state == OP_IND) ? PTR : ACC;
      PTR:  if (abort)             state_d = IDLE;
            else if (bus.DMem_rdy) state_d = (op_q == OP_IND) ? FIN : ACC;
      ACC:  if (abort)             state_d = IDLE;
            else if (bus.DMem_rdy) state_d = FIN;
      FIN:  state_d = IDLE;
    endcase
  end

  // An aborting cycle already drops the port and busy, so err lines up with
  // the last cycle the memory was waited on.
  always_comb begin
    en            = in_phase && !abort;
    bus.DMem_en   = en;
    bus.DMem_rd   = en && !is_write;
    bus.DMem_addr = en ? addr_q : '0;
    bus.DMem_din  = (en && is_write) ? data_q : '0;
    bus.busy      = en;
    bus.done      = (state_q == FIN);
    bus.err       = abort;
    bus.memout    = memout_q;
    state_dbg     = state_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= OP_NOP;
      memout_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.mem_state != OP_NOP) begin
                addr_q <= bus.M_addr;
                data_q <= bus.M_Data;
                op_q   <= bus.mem_state;
              end
        // The pointer replaces the captured address for the data phase.
        PTR:  if (bus.DMem_rdy) begin
                addr_q <= bus.DMem_dout[AW-1:0];
                if (op_q == OP_IND) memout_q <= bus.DMem_dout;
              end
        ACC:  if (bus.DMem_rdy && op_q != OP_WR) memout_q <= bus.DMem_dout;
        FIN:  ;
      endcase
      if (state_d != state_q)
        cnt_q <= '0;
      else if (in_phase && !bus.DMem_rdy && cnt_q != {TW{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_memaccess_ctrl.sv
// Bench for memaccess_ctrl: a 16-bit instance with TIMEOUT=4 and a 32/24-bit
// instance without timeout, checked every cycle against a transaction model.
module tb_memaccess_ctrl;

  localparam int W    = 93;
  localparam int TO_A = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memaccess_ctrl_if #(.DW(16), .AW(16)) ifa ();
  memaccess_ctrl_if #(.DW(32), .AW(24)) ifb ();
  logic [1:0] st_a, st_b;

  memaccess_ctrl #(.DW(16), .AW(16), .TIMEOUT(TO_A), .TW(8)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa), .state_dbg(st_a)
  );
  memaccess_ctrl #(.DW(32), .AW(24), .TIMEOUT(0), .TW(8)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb), .state_dbg(st_b)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0]  mem_m [2];
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] pack(bit en, bit rd, logic [23:0] a, logic [31:0] d,
                                        logic [31:0] m, bit busy, bit done, bit err);
    return {en, rd, a, d, m, busy, done, err};
  endfunction

  function automatic logic [W-1:0] idle(int k);
    return pack(1'b0, 1'b0, 24'd0, 32'd0, mem_m[k], 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      chk("cycle_a", pack(ifa.DMem_en, ifa.DMem_rd & ifa.DMem_en, 24'(ifa.DMem_addr),
                          32'(ifa.DMem_din), 32'(ifa.memout), ifa.busy, ifa.done, ifa.err), e);
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      chk("cycle_b", pack(ifb.DMem_en, ifb.DMem_rd & ifb.DMem_en, ifb.DMem_addr,
                          ifb.DMem_din, ifb.memout, ifb.busy, ifb.done, ifb.err), e);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_in(int sel, logic [1:0] ms, bit ctrl, logic [23:0] a, logic [31:0] d,
                          bit rdy, logic [31:0] dout);
    if (sel == 0) begin
      ifa.mem_state = ms;  ifa.M_control = ctrl; ifa.M_addr = a[15:0]; ifa.M_Data = d[15:0];
      ifa.DMem_rdy  = rdy; ifa.DMem_dout = dout[15:0];
      ifb.mem_state = 2'b11; ifb.M_control = 1'($urandom); ifb.M_addr = 24'($urandom);
      ifb.M_Data = $urandom; ifb.DMem_rdy = 1'($urandom); ifb.DMem_dout = $urandom;
    end else begin
      ifb.mem_state = ms;  ifb.M_control = ctrl; ifb.M_addr = a; ifb.M_Data = d;
      ifb.DMem_rdy  = rdy; ifb.DMem_dout = dout;
      ifa.mem_state = 2'b11; ifa.M_control = 1'($urandom); ifa.M_addr = 16'($urandom);
      ifa.M_Data = 16'($urandom); ifa.DMem_rdy = 1'($urandom); ifa.DMem_dout = 16'($urandom);
    end
  endtask

  task automatic cyc(int sel, logic [W-1:0] e);
    if (sel == 0) begin exp_q_a.push_back(e); exp_q_b.push_back(idle(1)); end
    else          begin exp_q_b.push_back(e); exp_q_a.push_back(idle(0)); end
    @(posedge clock); #1;
  endtask

  task automatic noise_cmd(int sel, bit rdy, logic [31:0] dout);
    drive_in(sel, 2'($urandom), 1'($urandom), 24'($urandom), $urandom, rdy, dout);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      drive_in(0, 2'b11, 1'($urandom), 24'($urandom), $urandom, 1'($urandom), $urandom);
      cyc(0, idle(0));
    end
  endtask

  // One memory phase answered after `waits` stalled cycles; ok=0 on timeout.
  task automatic phase(int sel, bit rd, logic [23:0] a, logic [31:0] d, int waits,
                       logic [31:0] rdata, output bit ok);
    int to;
    bit r;
    to = (sel == 0) ? TO_A : 0;
    ok = 1'b0;
    for (int j = 0; j <= waits; j++) begin
      r = (j == waits);
      noise_cmd(sel, r, r ? rdata : $urandom);
      if (to > 0 && j == to && !r) begin
        cyc(sel, pack(1'b0, 1'b0, 24'd0, 32'd0, mem_m[sel], 1'b0, 1'b0, 1'b1));
        return;
      end
      cyc(sel, pack(1'b1, rd, a, rd ? 32'd0 : d, mem_m[sel], 1'b1, 1'b0, 1'b0));
    end
    ok = 1'b1;
  endtask

  task automatic fin(int sel);
    noise_cmd(sel, 1'($urandom), $urandom);
    cyc(sel, pack(1'b0, 1'b0, 24'd0, 32'd0, mem_m[sel], 1'b0, 1'b1, 1'b0));
  endtask

  task automatic run_cmd(int sel, logic [1:0] op, bit ind, logic [23:0] addr, logic [31:0] data,
                         int w_ptr, logic [31:0] pw, int w_acc, logic [31:0] aw);
    logic [23:0] am;
    logic [31:0] dm;
    logic [23:0] a;
    bit ok;
    am = (sel != 0) ? 24'hFFFFFF : 24'h00FFFF;
    dm = (sel != 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
    addr &= am; data &= dm; pw &= dm; aw &= dm;
    drive_in(sel, op, ind, addr, data, 1'($urandom), $urandom);
    cyc(sel, idle(sel));
    a = addr;
    if (ind || op == 2'b00) begin
      phase(sel, 1'b1, addr, 32'd0, w_ptr, pw, ok);
      if (!ok) return;
      if (op == 2'b00) begin
        mem_m[sel] = pw;
        fin(sel);
        return;
      end
      a = pw[23:0] & am;
    end
    phase(sel, op != 2'b10, a, data, w_acc, aw, ok);
    if (!ok) return;
    if (op != 2'b10) mem_m[sel] = aw;
    fin(sel);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mem_m[0] = '0;
    mem_m[1] = '0;
    reset = 1'b1;
    drive_in(0, 2'b11, 1'b0, 24'd0, 32'd0, 1'b0, 32'd0);
    @(posedge clock); #1;
    chk("reset_state_a", W'(st_a), W'(0));
    chk("reset_state_b", W'(st_b), W'(0));
    cyc(0, idle(0));
    reset = 1'b0;
    idle_cycles(2);

    // direct read, immediate ready
    run_cmd(0, 2'b01, 1'b0, 24'h3000, 32'd0, 0, 32'd0, 0, 32'hBEEF);
    chk("direct_rd_memout", W'(ifa.memout), W'(16'hBEEF));
    // indirect read, pointer phase stalls twice
    run_cmd(0, 2'b01, 1'b1, 24'h3010, 32'd0, 2, 32'h4000, 0, 32'h1234);
    chk("indirect_rd_memout", W'(ifa.memout), W'(16'h1234));
    // indirect write leaves memout alone
    run_cmd(0, 2'b10, 1'b1, 24'h3020, 32'hA5A5, 0, 32'h5000, 0, 32'h0);
    chk("indirect_wr_memout", W'(ifa.memout), W'(16'h1234));
    // timeout in data phase, then a back-to-back command at the boundary
    run_cmd(0, 2'b01, 1'b0, 24'h3030, 32'd0, 0, 32'd0, 100, 32'h7777);
    chk("timeout_memout", W'(ifa.memout), W'(16'h1234));
    run_cmd(0, 2'b01, 1'b0, 24'h3040, 32'd0, 0, 32'd0, TO_A, 32'h5555);
    chk("boundary_rd_memout", W'(ifa.memout), W'(16'h5555));
    // timeout in pointer phase
    run_cmd(0, 2'b01, 1'b1, 24'h3050, 32'd0, 9, 32'h6000, 0, 32'h9999);
    chk("ptr_timeout_memout", W'(ifa.memout), W'(16'h5555));

    // reset during the data phase of an indirect read
    drive_in(0, 2'b01, 1'b1, 24'h3111, 32'd0, 1'b0, 32'd0);
    cyc(0, idle(0));
    noise_cmd(0, 1'b1, 32'h4321);
    cyc(0, pack(1'b1, 1'b1, 24'h3111, 32'd0, mem_m[0], 1'b1, 1'b0, 1'b0));
    noise_cmd(0, 1'b0, $urandom);
    cyc(0, pack(1'b1, 1'b1, 24'h4321, 32'd0, mem_m[0], 1'b1, 1'b0, 1'b0));
    noise_cmd(0, 1'b0, $urandom);
    reset = 1'b1;
    cyc(0, pack(1'b1, 1'b1, 24'h4321, 32'd0, mem_m[0], 1'b1, 1'b0, 1'b0));
    mem_m[0] = '0;
    mem_m[1] = '0;
    reset = 1'b0;
    chk("reset_mid_state", W'(st_a), W'(0));
    chk("reset_mid_memout", W'(ifa.memout), W'(0));
    chk("reset_mid_pulses", W'({ifa.done, ifa.err, ifa.DMem_en}), W'(0));
    idle_cycles(2);

    // wide instance: pointer truncated to 24 bits, full 32-bit data
    run_cmd(1, 2'b01, 1'b1, 24'h000100, 32'd0, 1, 32'hFF123456, 0, 32'hFF123456);
    chk("wide_memout", W'(ifb.memout), W'(32'hFF123456));
    run_cmd(1, 2'b00, 1'b0, 24'hABCDEF, 32'd0, 3, 32'h89ABCDEF, 0, 32'd0);
    chk("wide_ptr_only_memout", W'(ifb.memout), W'(32'h89ABCDEF));
    // no timeout: 300 stalls saturate the counter without aborting
    run_cmd(1, 2'b10, 1'b0, 24'h000200, 32'hDEADBEEF, 0, 32'd0, 300, 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(2, 0));
      run_cmd(int'(n % 2), op, 1'($urandom), 24'($urandom), $urandom,
              $urandom_range(6, 0), $urandom, $urandom_range(6, 0), $urandom);
      if ($urandom_range(3, 0) == 0) idle_cycles($urandom_range(2, 1));
    end

    idle_cycles(1);
    @(negedge clock); #1;
    chk("queue_a_drained", W'(exp_q_a.size()), W'(0));
    chk("queue_b_drained", W'(exp_q_b.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memaccess_ctrl.md
Name: memaccess_ctrl

Overview:
- Parametrised memory-access stage controller for the LC3 datapath; successor to the fixed 16-bit single-cycle memaccess stage.
- Accepts an access command (`mem_state`, `M_control`, `M_addr`, `M_Data`) and sequences direct or indirect reads and writes to data memory.
- Supports variable-latency memory through a ready handshake, with an optional timeout.
- Returns read data on `memout` and reports completion or error back to the controller.

Parameters:
- DW, 16: data width in bits.
- AW, 16: address width in bits. Must satisfy AW <= DW; an indirect pointer is `DMem_dout[AW-1:0]`.
- TIMEOUT, 0: maximum wait cycles per memory phase before abort. 0 disables the timeout.
- TW, 8: width of the wait counter. TIMEOUT must be < 2^TW.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- mem_state  in  2  command: 00 = indirect-address read, 01 = read, 10 = write, 11 = idle/no-op.
- M_control  in  1  1 = indirect access (fetch pointer first), 0 = direct.
- M_addr  in  AW  access address, or pointer address when indirect.
- M_Data  in  DW  store data for writes.
- DMem_dout  in  DW  memory read data; valid when DMem_rdy=1.
- DMem_rdy  in  1  memory completes the current phase this cycle.
- DMem_addr  out  AW  memory address.
- DMem_din  out  DW  memory write data.
- DMem_rd  out  1  1 = read phase, 0 = write phase; meaningful only while DMem_en=1.
- DMem_en  out  1  memory phase active.
- memout  out  DW  last completed read data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse: command completed.
- err  out  1  one-cycle pulse: command aborted on timeout.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including memout.
  - Wait counter cleared.
  - Reset overrides any phase in progress; no done or err pulse is generated.
- States: IDLE, PTR, ACC, FIN.
- IDLE:
  - When mem_state != 11, capture M_addr, M_Data, the operation and M_control into internal registers, set busy=1, and move to PTR if (M_control=1 or mem_state=00), else ACC.
  - mem_state=11 keeps the block in IDLE.
- PTR:
  - Drive DMem_en=1, DMem_rd=1, DMem_addr = captured address.
  - On DMem_rdy=1, latch the pointer = DMem_dout[AW-1:0] and clear the wait counter.
  - Then: if the operation is 00, finish as a read (memout <= DMem_dout, go to FIN). Otherwise go to ACC using the pointer as the address.
- ACC:
  - Drive DMem_en=1, DMem_addr = captured address or pointer.
  - Read: DMem_rd=1; on DMem_rdy=1, memout <= DMem_dout.
  - Write: DMem_rd=0, DMem_din = captured data; on DMem_rdy=1 the write is complete.
  - On DMem_rdy=1, go to FIN.
- FIN:
  - DMem_en=0, done=1 for exactly one cycle, busy=0 in this same cycle, then return to IDLE.
  - A new command is accepted from IDLE on the following cycle.
  - Minimum back-to-back period is 3 cycles for a direct command.
- Latency, command sampled at edge 0 with DMem_rdy held at 1:
  - Direct: ACC in cycle 1, done in cycle 2.
  - Indirect: PTR in cycle 1, ACC in cycle 2, done in cycle 3.
  - Each cycle with DMem_rdy=0 adds one cycle.
- Command inputs while busy: ignored. The captured values are used throughout the command.
- DMem_din is 0 outside write phases. DMem_addr is 0 when DMem_en=0.
- memout holds its value until the next completed read. Writes and timeouts never change memout.
- Timeout (TIMEOUT > 0):
  - The wait counter increments each PTR/ACC cycle with DMem_rdy=0.
  - When the counter equals TIMEOUT and DMem_rdy=0, abort: err=1 for one cycle, DMem_en=0, busy=0, return to IDLE, no done.
  - DMem_rdy=1 in the same cycle the counter reaches TIMEOUT counts as success, not an error.
  - The counter clears on every phase change.
- TIMEOUT=0: the controller waits indefinitely. The counter saturates at 2^TW-1 and never wraps.
- Width handling: the pointer is truncated to AW bits. No sign extension.

Test Plan:
- Direct read: mem_state=01, M_control=0, M_addr=0x3000, DMem_rdy=1, DMem_dout=0xBEEF -> DMem_en/rd=1 with DMem_addr=0x3000 in cycle 1; done in cycle 2; memout=0xBEEF.
- Indirect read with waits: mem_state=01, M_control=1, M_addr=0x3010; pointer phase returns 0x4000 after 2 rdy=0 cycles; data phase returns 0x1234 -> DMem_addr 0x3010 then 0x4000; done at cycle 5; memout=0x1234.
- Indirect write: mem_state=10, M_control=1, M_addr=0x3020, M_Data=0xA5A5, pointer=0x5000 -> write phase with DMem_rd=0, DMem_addr=0x5000, DMem_din=0xA5A5; done pulse; memout unchanged.
- Timeout: TIMEOUT=4, direct read, DMem_rdy held 0 -> err pulse one cycle after the 4th wait cycle; no done; busy=0; a next command is accepted. A variant with rdy=1 on the 4th wait cycle -> done, no err.
- Reset mid-operation: assert reset during ACC of an indirect read -> next cycle all outputs 0, state IDLE, no done/err; changing mem_state while busy does not alter DMem_addr.
- Parameter sweep: DW=32, AW=24, indirect read with DMem_dout=0xFF123456 -> pointer 0x123456; memout carries the full 32-bit data word.
